// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if
// Groups the instruction handshake and the datapath control outputs of
// alu_op_sequencer into one bundle.
//   master : instruction source (drives instr_valid/instr, observes the rest)
//   slave  : the sequencer (samples instr_valid/instr, drives controls)
// Signals:
//   instr_valid/instr/instr_ready : instruction valid/ready handshake
//   busy                          : sequencer not idle
//   sel_a/sel_b                   : operand mux selects
//   imm_sel/imm_value             : immediate operand select and value
//   alu_op                        : effective ALU opcode
//   reg_wen                       : one-hot register bank write enable
//   flags_we                      : PSR flag write strobe
//   illegal                       : rejected-instruction pulse
interface alu_op_sequencer_if;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        busy;
  logic [3:0]  sel_a;
  logic [3:0]  sel_b;
  logic        imm_sel;
  logic [15:0] imm_value;
  logic [3:0]  alu_op;
  logic [15:0] reg_wen;
  logic        flags_we;
  logic        illegal;

  modport master (
    output instr_valid, instr,
    input  instr_ready, busy, sel_a, sel_b, imm_sel, imm_value,
           alu_op, reg_wen, flags_we, illegal
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, busy, sel_a, sel_b, imm_sel, imm_value,
           alu_op, reg_wen, flags_we, illegal
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Sequences one register-register or register-immediate ALU instruction at a
// time through READ (operand selects stable), EXEC (mux outputs valid, ALU
// settles) and WB (register/flag write strobes). Instructions naming the
// reserved registers (index >= NUM_USABLE_REGS) are rejected with a one-cycle
// illegal pulse and never touch the register bank or flags.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : alu_op_sequencer_if.slave (handshake + datapath controls)
module alu_op_sequencer #(
  parameter int         NUM_USABLE_REGS = 13,
  parameter logic [3:0] CMP_OP          = 4'hB,
  parameter bit         IMM_SIGN_EXT    = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  alu_op_sequencer_if.slave  bus
);

  localparam logic [4:0] REG_LIM = 5'(NUM_USABLE_REGS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB,
    S_ERR
  } state_t;

  state_t      r_state;
  logic [3:0]  r_sel_a;
  logic [3:0]  r_sel_b;
  logic        r_imm_sel;
  logic [15:0] r_imm_value;
  logic [3:0]  r_alu_op;
  logic [15:0] r_reg_wen;
  logic        r_flags_we;
  logic        r_illegal;

  // Instruction field decode, only consumed on a transfer.
  logic [3:0]  w_op;
  logic [3:0]  w_rdest;
  logic [3:0]  w_ext;
  logic [3:0]  w_rsrc;
  logic [15:0] w_imm;
  logic        w_illegal;

  assign w_op    = bus.instr[15:12];
  assign w_rdest = bus.instr[11:8];
  assign w_ext   = bus.instr[7:4];
  assign w_rsrc  = bus.instr[3:0];
  assign w_imm   = IMM_SIGN_EXT ? {{8{bus.instr[7]}}, bus.instr[7:0]}
                                : {8'h00, bus.instr[7:0]};

  // rsrc only names a register in register form; in immediate form it is
  // the low nibble of the immediate and is not range-checked.
  assign w_illegal = ({1'b0, w_rdest} >= REG_LIM) ||
                     ((w_op == 4'h0) && ({1'b0, w_rsrc} >= REG_LIM));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_sel_a     <= '0;
      r_sel_b     <= '0;
      r_imm_sel   <= 1'b0;
      r_imm_value <= '0;
      r_alu_op    <= '0;
      r_reg_wen   <= '0;
      r_flags_we  <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      // Strobes default low so each one is a single-cycle pulse.
      r_reg_wen  <= '0;
      r_flags_we <= 1'b0;
      r_illegal  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.instr_valid) begin
            if (w_illegal) begin
              // Rejected instructions leave the operand selects untouched
              // so the datapath keeps its last stable configuration.
              r_state   <= S_ERR;
              r_illegal <= 1'b1;
            end else begin
              r_state     <= S_READ;
              r_sel_a     <= w_rdest;
              r_sel_b     <= w_rsrc;
              r_imm_sel   <= (w_op != 4'h0);
              r_imm_value <= w_imm;
              r_alu_op    <= (w_op == 4'h0) ? w_ext : w_op;
            end
          end
        end
        S_READ: r_state <= S_EXEC;
        S_EXEC: begin
          // Strobes are set on the way into WB so they are registered
          // outputs that are high exactly during the WB cycle.
          r_state    <= S_WB;
          r_flags_we <= 1'b1;
          if ((r_alu_op != CMP_OP) && ({1'b0, r_sel_a} < REG_LIM))
            r_reg_wen <= 16'h0001 << r_sel_a;
        end
        S_WB:    r_state <= S_IDLE;
        S_ERR:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.instr_ready = (r_state == S_IDLE) & ~reset;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.sel_a       = r_sel_a;
  assign bus.sel_b       = r_sel_b;
  assign bus.imm_sel     = r_imm_sel;
  assign bus.imm_value   = r_imm_value;
  assign bus.alu_op      = r_alu_op;
  assign bus.reg_wen     = r_reg_wen;
  assign bus.flags_we    = r_flags_we;
  assign bus.illegal     = r_illegal;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
// Directed stimulus against alu_op_sequencer. A cycle-indexed schedule model
// predicts every output each cycle; literal checks pin key expectations.
module tb_alu_op_sequencer;

  logic clk;
  logic reset;

  alu_op_sequencer_if bus ();

  alu_op_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // Events are scheduled by absolute cycle number; a cycle index c means the
  // period following the c-th rising edge.
  logic [15:0] wen_s [int];
  bit          flg_s [int];
  bit          ill_s [int];
  int          ready_cyc = 0;
  bit          m_valid   = 0;
  bit          m_acc     = 0;
  int          f_sela = 0, f_selb = 0, f_imms = 0, f_immv = 0, f_alu = 0;

  always @(posedge clk) begin
    m_acc = 0;
    if (reset) begin
      wen_s.delete();
      flg_s.delete();
      ill_s.delete();
      ready_cyc = cyc + 1;
      f_sela = 0; f_selb = 0; f_imms = 0; f_immv = 0; f_alu = 0;
      m_valid = 1;
    end else if (m_valid && bus.instr_valid && cyc >= ready_cyc) begin
      int op, rd, ex, rs, imm;
      op = int'(bus.instr[15:12]);
      rd = int'(bus.instr[11:8]);
      ex = int'(bus.instr[7:4]);
      rs = int'(bus.instr[3:0]);
      m_acc = 1;
      if (rd >= 13 || (op == 0 && rs >= 13)) begin
        ill_s[cyc + 1] = 1;
        ready_cyc = cyc + 2;
      end else begin
        imm = ex * 16 + rs;
        if (imm >= 128) imm = imm + 65280;
        f_sela = rd;
        f_selb = rs;
        f_imms = (op != 0) ? 1 : 0;
        f_immv = imm;
        f_alu  = (op == 0) ? ex : op;
        wen_s[cyc + 3] = (f_alu == 11) ? 16'h0000 : 16'(1 << rd);
        flg_s[cyc + 3] = 1;
        ready_cyc = cyc + 4;
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("instr_ready", 32'(bus.instr_ready), 32'((cyc >= ready_cyc) && !reset));
      chk("busy",        32'(bus.busy),        32'(cyc < ready_cyc));
      chk("sel_a",       32'(bus.sel_a),       32'(f_sela));
      chk("sel_b",       32'(bus.sel_b),       32'(f_selb));
      chk("imm_sel",     32'(bus.imm_sel),     32'(f_imms));
      chk("imm_value",   32'(bus.imm_value),   32'(f_immv));
      chk("alu_op",      32'(bus.alu_op),      32'(f_alu));
      chk("reg_wen",     32'(bus.reg_wen),     wen_s.exists(cyc) ? 32'(wen_s[cyc]) : 32'h0);
      chk("flags_we",    32'(bus.flags_we),    flg_s.exists(cyc) ? 32'(flg_s[cyc]) : 32'h0);
      chk("illegal",     32'(bus.illegal),     ill_s.exists(cyc) ? 32'(ill_s[cyc]) : 32'h0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Waits for the model to see a transfer; returns the cycle after the edge.
  task automatic wait_acc(output int c);
    bit ok;
    ok = 0;
    c  = -1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (m_acc) begin
        ok = 1;
        c  = cyc;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 32'h0, 32'h1);
  endtask

  task automatic send(input logic [15:0] x, output int c);
    bus.instr_valid = 1'b1;
    bus.instr       = x;
    wait_acc(c);
    bus.instr_valid = 1'b0;
    bus.instr       = 16'hDEAD;
  endtask

  initial begin
    int t, t2;
    reset           = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    tick(2);
    reset = 1'b0;
    tick(1);
    // reset then idle
    chk("rst_ready",  32'(bus.instr_ready), 32'h1);
    chk("rst_busy",   32'(bus.busy),        32'h0);
    chk("rst_wen",    32'(bus.reg_wen),     32'h0);
    chk("rst_immv",   32'(bus.imm_value),   32'h0);
    chk("rst_alu",    32'(bus.alu_op),      32'h0);

    // register ADD
    send(16'h0355, t);
    chk("add_sela", 32'(bus.sel_a),   32'h3);
    chk("add_selb", 32'(bus.sel_b),   32'h5);
    chk("add_alu",  32'(bus.alu_op),  32'h5);
    chk("add_imms", 32'(bus.imm_sel), 32'h0);
    tick(2);
    chk("add_wen",  32'(bus.reg_wen),  32'h0008);
    chk("add_flg",  32'(bus.flags_we), 32'h1);
    tick(1);
    chk("add_rdy",  32'(bus.instr_ready), 32'h1);
    chk("add_wen0", 32'(bus.reg_wen),     32'h0);
    tick(1);

    // immediate, sign-extended
    send(16'h52FF, t);
    chk("imm_val",  32'(bus.imm_value), 32'hFFFF);
    chk("imm_sel",  32'(bus.imm_sel),   32'h1);
    chk("imm_alu",  32'(bus.alu_op),    32'h5);
    chk("imm_sela", 32'(bus.sel_a),     32'h2);
    tick(2);
    chk("imm_wen",  32'(bus.reg_wen),   32'h0004);
    tick(2);

    // compare: flags only
    send(16'h01B2, t);
    tick(2);
    chk("cmp_flg", 32'(bus.flags_we), 32'h1);
    chk("cmp_wen", 32'(bus.reg_wen),  32'h0);
    tick(2);

    // reserved destination
    send(16'h0D51, t);
    chk("ill_rd",    32'(bus.illegal),     32'h1);
    tick(1);
    chk("ill_rd_0",  32'(bus.illegal),     32'h0);
    chk("ill_rdy",   32'(bus.instr_ready), 32'h1);
    tick(1);
    // reserved source in register form
    send(16'h015E, t);
    chk("ill_rs",    32'(bus.illegal),     32'h1);
    tick(1);
    chk("ill_rs_rdy", 32'(bus.instr_ready), 32'h1);
    // rsrc=14 in immediate form is just immediate bits: legal
    send(16'h713E, t);
    chk("imm_rs_ok", 32'(bus.illegal),   32'h0);
    chk("imm_zext",  32'(bus.imm_value), 32'h003E);
    tick(4);

    // reset during EXEC
    send(16'h0355, t);
    tick(1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("mid_busy", 32'(bus.busy), 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("mid_wen", 32'(bus.reg_wen), 32'h0);
      tick(1);
    end

    // back-to-back with instr_valid held high
    bus.instr_valid = 1'b1;
    bus.instr       = 16'h0355;
    wait_acc(t);
    bus.instr       = 16'h0466;
    wait_acc(t2);
    bus.instr_valid = 1'b0;
    chk("b2b_gap", 32'(t2 - t), 32'h4);
    tick(2);
    chk("b2b_wen2", 32'(bus.reg_wen), 32'h0010);
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout cyc=%0d got=running want=done", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Multi-cycle controller that sequences the 16-entry register bank and the registered ALU operand muxes for one register-register or register-immediate ALU instruction at a time.
- Accepts a 16-bit instruction over a valid/ready handshake.
- Drives operand mux selects, immediate select/value, ALU opcode, one-hot register write enables and flag write strobe.
- Rejects instructions that name reserved registers r13–r15 (PC, ISP, INTBASE).
- Sits between the instruction source (fetch/test harness) and the register bank + ALU datapath.

Parameters:
NUM_USABLE_REGS, 13, registers 0..NUM_USABLE_REGS-1 are legal operands/destinations; indices >= this are reserved.
CMP_OP, 4'hB, effective ALU opcode that updates flags only (no register write-back).
IMM_SIGN_EXT, 1, 1 = sign-extend imm8 to 16 bits; 0 = zero-extend.

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
instr_valid  input  1  instruction present on instr
instr  input  16  [15:12] op, [11:8] rdest, [7:4] ext, [3:0] rsrc
instr_ready  output  1  sequencer can accept an instruction this cycle
busy  output  1  high in every state except IDLE
sel_a  output  4  operand A mux select (= rdest)
sel_b  output  4  operand B mux select (= rsrc)
imm_sel  output  1  1 = ALU B operand is imm_value instead of mux B
imm_value  output  16  extended immediate {ext,rsrc}
alu_op  output  4  effective ALU opcode
reg_wen  output  16  one-hot register write enable (bank rEnable)
flags_we  output  1  one-cycle PSR flag write strobe
illegal  output  1  one-cycle pulse: rejected instruction

Behaviour:
- Reset: synchronous, active-high on reset; clock clk. On reset: state IDLE; sel_a=0, sel_b=0, imm_sel=0, imm_value=0, alu_op=0, reg_wen=0, flags_we=0, illegal=0, busy=0, instr_ready=1 in the first cycle after reset deasserts.
- Handshake: transfer occurs on a rising edge with instr_valid & instr_ready. instr_ready = (state==IDLE) & ~reset. instr is sampled only at transfer; later changes are ignored.
- Decode at transfer (registered into internal fields):
  - op==0: register form. alu_op=ext, imm_sel=0.
  - op!=0: immediate form. alu_op=op, imm_sel=1, imm_value = extend({ext,rsrc}) per IMM_SIGN_EXT.
  - sel_a=rdest; sel_b=rsrc.
  - Illegal if rdest >= NUM_USABLE_REGS, or if op==0 and rsrc >= NUM_USABLE_REGS. rsrc is not checked in immediate form.
- FSM states: IDLE, READ, EXEC, WB, ERR.
  - IDLE -> READ on a legal transfer; IDLE -> ERR on an illegal transfer; otherwise hold.
  - READ: selects stable; the registered operand muxes capture at the end of this cycle.
  - EXEC: mux outputs valid; ALU result settles combinationally.
  - WB: reg_wen[rdest]=1 unless alu_op==CMP_OP (then reg_wen=0); flags_we=1 for every legal op. -> IDLE.
  - ERR: illegal=1, reg_wen=0, flags_we=0. -> IDLE.
- Latency for a legal op, transfer at edge T:
  - READ in cycle T+1, EXEC in T+2, WB in T+3.
  - Register updated at the edge ending T+3.
  - instr_ready=1 again in T+4; throughput one instruction per 4 cycles.
- Latency for an illegal op: illegal pulse in T+1, ready again in T+2.
- Output stability: sel_a, sel_b, imm_sel, imm_value and alu_op hold from READ through WB and keep their last values in IDLE/ERR.
- Strobes: reg_wen is zero outside WB and is never multi-hot; bits 13–15 can never assert. flags_we and illegal are single-cycle pulses.
- Reset mid-operation: any state -> IDLE on the next edge. No reg_wen/flags_we/illegal is asserted in the cycle following the reset edge, and the in-flight instruction is discarded.
- instr_valid held high continuously: a new instruction is accepted on each IDLE cycle, i.e. every 4th cycle for legal ops.

Test Plan:
- Reset then idle: reset 2 cycles, instr_valid=0 -> instr_ready=1, busy=0, reg_wen=0x0000, all outputs 0.
- Register ADD 0x0355 (rdest=3, ext=5, rsrc=5) accepted at T -> sel_a=3, sel_b=5, imm_sel=0, alu_op=5 from T+1; reg_wen=0x0008 and flags_we=1 only in T+3; instr_ready=1 at T+4.
- Immediate 0x52FF, IMM_SIGN_EXT=1 -> alu_op=5, sel_a=2, imm_sel=1, imm_value=0xFFFF; reg_wen=0x0004 in WB.
- CMP 0x01B2 (ext=0xB) -> flags_we=1 in WB, reg_wen stays 0x0000 in all cycles.
- Reserved register: 0x0D51 (rdest=13) -> illegal=1 at T+1 only, reg_wen and flags_we never assert, ready at T+2; 0x015E (op 0, rsrc=14) likewise illegal.
- Reset asserted during EXEC of 0x0355, plus back-to-back: reset in EXEC -> no reg_wen in any later cycle, IDLE next cycle; then instr_valid held high with 0x0355, 0x0466 -> second accept exactly 4 cycles after the first, reg_wen 0x0008 then 0x0010.
